// File: rtl/pconv_mac_relu.sv
// pconv_mac_relu: pointwise-convolution MAC with bias, arithmetic shift,
// ReLU and saturation. Three-stage pipeline:
//   stage 1: product register, channel counter, per-group bias/shift latch
//   stage 2: accumulator, hand-off of bias/shift on the group's last beat
//   stage 3: bias add, (optional rounding), shift, ReLU + clamp to N bits
// Optional feature: define PCONV_ROUND_EN for round-half-up before the shift.
module pconv_mac_relu #(
  parameter int N       = 16,
  parameter int ACC_W   = 32,
  parameter int CH      = 8,
  parameter int SHIFT_W = 5,
  localparam int CNT_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      input_vld,
  input  logic signed [N-1:0]       input_din,
  input  logic signed [N-1:0]       weight_din,
  input  logic signed [ACC_W-1:0]   bias_din,
  input  logic        [SHIFT_W-1:0] shift_din,
  output logic        [CNT_W-1:0]   ch_cnt,
  output logic signed [N-1:0]       conv_dout,
  output logic                      conv_dout_vld
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CH - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};

  // stage 1 state
  logic signed [2*N-1:0]   mult;
  logic signed [ACC_W-1:0] prod;
  logic                    p_vld;
  logic                    p_first;
  logic                    p_last;
  logic signed [ACC_W-1:0] bias_l;
  logic [SHIFT_W-1:0]      shift_l;

  // stage 2 state
  logic signed [ACC_W-1:0] acc;
  logic                    s_vld;
  logic signed [ACC_W-1:0] bias_h;
  logic [SHIFT_W-1:0]      shift_h;

  // stage 3 combinational
  logic signed [ACC_W-1:0] t;
  logic signed [ACC_W-1:0] u;
  logic signed [N-1:0]     sat;
`ifdef PCONV_ROUND_EN
  logic [ACC_W-1:0]        rnd;
`endif

  // Full-precision signed product of the current beat
  always_comb begin
    mult = input_din * weight_din;
  end

  // Stage 1: register product, tag first/last, latch group bias/shift, count channels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt  <= '0;
      prod    <= '0;
      p_vld   <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      bias_l  <= '0;
      shift_l <= '0;
    end else if (clr) begin
      ch_cnt <= '0;
      p_vld  <= 1'b0;
    end else if (input_vld) begin
      prod    <= ACC_W'(mult);
      p_vld   <= 1'b1;
      p_first <= (ch_cnt == '0);
      p_last  <= (ch_cnt == LAST_CNT);
      if (ch_cnt == '0) begin
        bias_l  <= bias_din;
        shift_l <= shift_din;
      end
      if (ch_cnt == LAST_CNT) ch_cnt <= '0;
      else                    ch_cnt <= ch_cnt + CNT_W'(1);
    end else begin
      p_vld <= 1'b0;
    end
  end

  // Stage 2: accumulate modulo 2^ACC_W; on the last beat pass the group on
  // together with its bias/shift so stage 1 can already latch the next group's
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      s_vld   <= 1'b0;
      bias_h  <= '0;
      shift_h <= '0;
    end else if (clr) begin
      s_vld <= 1'b0;
    end else if (p_vld) begin
      acc   <= p_first ? prod : acc + prod;
      s_vld <= p_last;
      if (p_last) begin
        bias_h  <= bias_l;
        shift_h <= shift_l;
      end
    end else begin
      s_vld <= 1'b0;
    end
  end

  // Stage 3 datapath: bias, optional rounding, arithmetic shift, ReLU, clamp
  always_comb begin
    t = acc + bias_h;
`ifdef PCONV_ROUND_EN
    rnd = '0;
    if (shift_h != '0) begin
      rnd = {{(ACC_W-1){1'b0}}, 1'b1} << (shift_h - SHIFT_W'(1));
    end
    t = t + $signed(rnd);
`endif
    if (int'(shift_h) >= ACC_W) u = {ACC_W{t[ACC_W-1]}};
    else                        u = t >>> shift_h;
    if (u[ACC_W-1])        sat = '0;
    else if (u > OUT_MAX)  sat = OUT_MAX[N-1:0];
    else                   sat = u[N-1:0];
  end

  // Stage 3 register: one-cycle valid pulse, data holds between results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_dout     <= '0;
      conv_dout_vld <= 1'b0;
    end else if (clr) begin
      conv_dout_vld <= 1'b0;
    end else if (s_vld) begin
      conv_dout     <= sat;
      conv_dout_vld <= 1'b1;
    end else begin
      conv_dout_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pconv_mac_relu.sv
// Testbench for pconv_mac_relu: directed plan cases followed by random
// traffic, checked every cycle against a group-level arithmetic model.
// A second instance with CH=1 shares the stimulus.
module tb_pconv_mac_relu;

  localparam int N       = 16;
  localparam int ACC_W   = 32;
  localparam int CH      = 4;
  localparam int SHIFT_W = 5;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      clr = 1'b0;
  logic                      input_vld = 1'b0;
  logic signed [N-1:0]       input_din = '0;
  logic signed [N-1:0]       weight_din = '0;
  logic signed [ACC_W-1:0]   bias_din = '0;
  logic        [SHIFT_W-1:0] shift_din = '0;
  logic [1:0]                ch_cnt;
  logic [N-1:0]              conv_dout;
  logic                      conv_dout_vld;
  logic [0:0]                ch_cnt1;
  logic [N-1:0]              conv_dout1;
  logic                      conv_dout_vld1;

  always #5 clk = ~clk;

  pconv_mac_relu #(.N(N), .ACC_W(ACC_W), .CH(CH), .SHIFT_W(SHIFT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .input_vld(input_vld),
    .input_din(input_din), .weight_din(weight_din), .bias_din(bias_din),
    .shift_din(shift_din), .ch_cnt(ch_cnt), .conv_dout(conv_dout),
    .conv_dout_vld(conv_dout_vld));

  pconv_mac_relu #(.N(N), .ACC_W(ACC_W), .CH(1), .SHIFT_W(SHIFT_W)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .input_vld(input_vld),
    .input_din(input_din), .weight_din(weight_din), .bias_din(bias_din),
    .shift_din(shift_din), .ch_cnt(ch_cnt1), .conv_dout(conv_dout1),
    .conv_dout_vld(conv_dout_vld1));

  int vecs = 0;
  int errs = 0;
  int tcount = 0;

  // reference model state
  int          m_cnt;
  longint      m_sum, m_bias;
  int          m_shift;
  int          due_q[$];
  logic [15:0] val_q[$];
  logic [15:0] m_out;
  int          due1_q[$];
  logic [15:0] val1_q[$];
  logic [15:0] m_out1;

  function automatic longint wrap32(longint x);
    int y;
    y = int'(x);
    return longint'(y);
  endfunction

  // Result of one group from its dot product, bias and shift
  function automatic logic [15:0] ref_result(longint sum, longint bias, int sh);
    longint tt, uu;
    logic [15:0] r;
    tt = wrap32(sum + bias);
`ifdef PCONV_ROUND_EN
    if (sh > 0) tt = wrap32(tt + (longint'(1) << (sh - 1)));
`endif
    uu = tt >>> sh;
    if (uu < 0)          r = 16'd0;
    else if (uu > 32767) r = 16'd32767;
    else                 r = uu[15:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_sum = 0; m_bias = 0; m_shift = 0; m_out = '0; m_out1 = '0;
    due_q.delete(); val_q.delete(); due1_q.delete(); val1_q.delete();
  endtask

  // One clock: update the model from the inputs sampled at the edge,
  // then compare every output of both instances.
  task automatic tick();
    longint p;
    logic exp_v, exp_v1;
    @(posedge clk);
    tcount++;
    if (clr) begin
      m_cnt = 0; m_sum = 0;
      due_q.delete(); val_q.delete(); due1_q.delete(); val1_q.delete();
    end else if (input_vld) begin
      p = longint'(input_din) * longint'(weight_din);
      if (m_cnt == 0) begin
        m_bias = longint'(bias_din); m_shift = int'(shift_din); m_sum = 0;
      end
      m_sum += p;
      m_cnt++;
      if (m_cnt == CH) begin
        due_q.push_back(tcount + 2);
        val_q.push_back(ref_result(m_sum, m_bias, m_shift));
        m_cnt = 0;
      end
      due1_q.push_back(tcount + 2);
      val1_q.push_back(ref_result(p, longint'(bias_din), int'(shift_din)));
    end
    #1;
    exp_v = 1'b0;
    if (due_q.size() > 0 && due_q[0] == tcount) begin
      exp_v = 1'b1; m_out = val_q[0];
      void'(due_q.pop_front()); void'(val_q.pop_front());
    end
    exp_v1 = 1'b0;
    if (due1_q.size() > 0 && due1_q[0] == tcount) begin
      exp_v1 = 1'b1; m_out1 = val1_q[0];
      void'(due1_q.pop_front()); void'(val1_q.pop_front());
    end
    chk("vld", conv_dout_vld, exp_v);
    chk("dout", conv_dout, m_out);
    chk("ch_cnt", ch_cnt, m_cnt);
    chk("ch1_vld", conv_dout_vld1, exp_v1);
    chk("ch1_dout", conv_dout1, m_out1);
    chk("ch1_cnt", ch_cnt1, 0);
  endtask

  task automatic beat(input int a, input int w, input int b, input int s);
    clr = 1'b0; input_vld = 1'b1;
    input_din = N'(a); weight_din = N'(w); bias_din = ACC_W'(b); shift_din = SHIFT_W'(s);
    tick();
    input_vld = 1'b0;
    // scramble bias/shift between beats: only the channel-0 values may matter
    bias_din = $urandom; shift_din = SHIFT_W'($urandom);
  endtask

  task automatic idle(input int n);
    clr = 1'b0; input_vld = 1'b0;
    repeat (n) tick();
  endtask

  task automatic grp4(input int a0, input int a1, input int a2, input int a3,
                      input int w, input int b, input int s);
    beat(a0, w, b, s); beat(a1, w, b, s); beat(a2, w, b, s); beat(a3, w, b, s);
  endtask

  initial begin
    model_reset();
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", conv_dout, 0);
    chk("rst_vld", conv_dout_vld, 0);
    chk("rst_cnt", ch_cnt, 0);
    rst_n = 1'b1;

    // basic dot product: 1..4 x 2 = 20
    grp4(1, 2, 3, 4, 2, 0, 0);
    idle(2);
    chk("t1_result", conv_dout, 20);
    idle(1);
    chk("t1_pulse_end", conv_dout_vld, 0);

    // negative sum with bias -> ReLU to 0
    grp4(5, 5, 5, 5, -3, 10, 0);
    idle(2);
    chk("t2_relu", conv_dout, 0);
    chk("t2_vld", conv_dout_vld, 1);
    idle(1);

    // 4 * 2^28 = 2^30 -> saturate
    grp4(16384, 16384, 16384, 16384, 16384, 0, 0);
    idle(2);
    chk("t3_sat", conv_dout, 32767);
    idle(1);

    // 20 + 3 = 23, >>> 3
    grp4(1, 2, 3, 4, 2, 3, 3);
    idle(2);
`ifdef PCONV_ROUND_EN
    chk("t4_shift", conv_dout, 3);
`else
    chk("t4_shift", conv_dout, 2);
`endif
    idle(1);

    // gap of 3 idle cycles inside a group
    beat(1, 2, 0, 0); beat(2, 2, 0, 0);
    idle(3);
    beat(3, 2, 0, 0); beat(4, 2, 0, 0);
    idle(2);
    chk("gap_result", conv_dout, 20);
    idle(1);

    // clr after beat 2, with a simultaneous beat that must be dropped
    beat(9, 9, 0, 0); beat(9, 9, 0, 0);
    clr = 1'b1; input_vld = 1'b1; input_din = 16'sd100; weight_din = 16'sd100;
    tick();
    clr = 1'b0; input_vld = 1'b0;
    chk("clr_cnt", ch_cnt, 0);
    grp4(7, 7, 7, 7, 1, 0, 0);
    idle(2);
    chk("post_clr_result", conv_dout, 28);
    idle(1);

    // clr right after a group's last beat: that group never appears
    grp4(1, 1, 1, 1, 1, 0, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    idle(3);
    chk("clr_kill_hold", conv_dout, 28);

    // back-to-back groups with different biases: 10+100, 10+200
    grp4(1, 2, 3, 4, 1, 100, 0);
    grp4(1, 2, 3, 4, 1, 200, 0);
    idle(1);
    chk("b2b_second_pending", conv_dout, 110);
    idle(1);
    chk("b2b_second", conv_dout, 210);
    idle(1);

    // asynchronous reset mid-group
    beat(3, 3, 0, 0); beat(3, 3, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", conv_dout, 0);
    chk("arst_vld", conv_dout_vld, 0);
    chk("arst_cnt", ch_cnt, 0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    grp4(1, 2, 3, 4, 2, 0, 0);
    idle(2);
    chk("post_rst_result", conv_dout, 20);
    idle(1);

    // random traffic with gaps and occasional aborts
    for (int i = 0; i < 400; i++) begin
      clr       = ($urandom_range(0, 40) == 0);
      input_vld = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        input_din  = N'($signed($urandom_range(0, 200)) - 100);
        weight_din = N'($signed($urandom_range(0, 200)) - 100);
        bias_din   = ACC_W'($signed($urandom_range(0, 2000)) - 1000);
        shift_din  = SHIFT_W'($urandom_range(0, 4));
      end else begin
        input_din  = N'($urandom);
        weight_din = N'($urandom);
        bias_din   = ACC_W'($urandom);
        shift_din  = SHIFT_W'($urandom_range(0, 31));
      end
      tick();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
